// File: rtl/pu_rf_wb_arb.sv
// pu_rf_wb_arb: merges ALU results and queued load responses onto the
// register-file write port, with a per-register pending scoreboard.
// Ports: clk, rst_n (async, active-low); ALU in: alu_valid/alu_waddr/
// alu_data; load: ld_issue/ld_issue_waddr, ld_rsp_valid/ld_rsp_ready/
// ld_rsp_waddr/ld_rsp_data; issue: rd_addr0/rd_addr1 -> hazard;
// write port: wr/waddr/din; status: alu_stall, lq_count, lq_full,
// proto_err. Define PU_RF_WB_STARVE_EN to build the starvation counter.
module pu_rf_wb_arb #(
  parameter int WIDTH        = 32,
  parameter int DEPTH_NBITS  = 5,
  parameter int LQ_NBITS     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_valid,
  input  logic [DEPTH_NBITS-1:0] alu_waddr,
  input  logic [WIDTH-1:0]       alu_data,
  input  logic                   ld_issue,
  input  logic [DEPTH_NBITS-1:0] ld_issue_waddr,
  input  logic                   ld_rsp_valid,
  output logic                   ld_rsp_ready,
  input  logic [DEPTH_NBITS-1:0] ld_rsp_waddr,
  input  logic [WIDTH-1:0]       ld_rsp_data,
  input  logic [DEPTH_NBITS-1:0] rd_addr0,
  input  logic [DEPTH_NBITS-1:0] rd_addr1,
  output logic                   hazard,
  output logic                   alu_stall,
  output logic                   wr,
  output logic [DEPTH_NBITS-1:0] waddr,
  output logic [WIDTH-1:0]       din,
  output logic [LQ_NBITS:0]      lq_count,
  output logic                   lq_full,
  output logic                   proto_err
);

  localparam int NREG = 1 << DEPTH_NBITS;
  localparam int LQD  = 1 << LQ_NBITS;

  logic [DEPTH_NBITS-1:0] qa_mem [LQD];
  logic [WIDTH-1:0]       qd_mem [LQD];

  logic [LQ_NBITS:0]      cnt_q, cnt_d;
  logic [LQ_NBITS-1:0]    wp_q, rp_q;
  logic [NREG-1:0]        pend_q, pend_d;
  logic                   wr_q, wr_d;
  logic [DEPTH_NBITS-1:0] waddr_q, waddr_d;
  logic [WIDTH-1:0]       din_q, din_d;
  logic                   err_q, err_d;
  logic                   stall_q;

  logic                   push, pop, alu_win;
  logic                   empty, avail;
  logic [DEPTH_NBITS-1:0] head_a;
  logic [WIDTH-1:0]       head_d;

  // Only a full count sets the top bit.
  assign lq_full      = cnt_q[LQ_NBITS];
  assign ld_rsp_ready = !lq_full;
  assign lq_count     = cnt_q;
  assign push         = ld_rsp_valid & ld_rsp_ready;
  assign empty        = (cnt_q == '0);
  // An empty queue bypasses the incoming response as its head.
  assign avail        = !empty | push;
  assign head_a       = empty ? ld_rsp_waddr : qa_mem[rp_q];
  assign head_d       = empty ? ld_rsp_data  : qd_mem[rp_q];

  always_comb begin
    pop     = 1'b0;
    alu_win = 1'b0;
`ifdef PU_RF_WB_STARVE_EN
    if (stall_q & avail)
      pop = 1'b1;
    else if (alu_valid & !stall_q)
      alu_win = 1'b1;
    else if (avail)
      pop = 1'b1;
`else
    if (alu_valid)
      alu_win = 1'b1;
    else if (avail)
      pop = 1'b1;
`endif
  end

  always_comb begin
    wr_d    = alu_win | pop;
    waddr_d = waddr_q;
    din_d   = din_q;
    if (alu_win) begin
      waddr_d = alu_waddr;
      din_d   = alu_data;
    end else if (pop) begin
      waddr_d = head_a;
      din_d   = head_d;
    end
    cnt_d = cnt_q + (LQ_NBITS+1)'(push)
                  - (LQ_NBITS+1)'(pop);
    // Set after clear so a same-cycle issue keeps the bit.
    pend_d = pend_q;
    if (pop)
      pend_d[head_a] = 1'b0;
    if (ld_issue)
      pend_d[ld_issue_waddr] = 1'b1;
    err_d = err_q
          | (ld_rsp_valid & !ld_rsp_ready)
          | (alu_win & pend_q[alu_waddr])
          | (pop & !pend_q[head_a]);
`ifdef PU_RF_WB_STARVE_EN
    err_d = err_d | (alu_valid & stall_q);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      pend_q  <= '0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      din_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      wp_q    <= wp_q + LQ_NBITS'(push);
      rp_q    <= rp_q + LQ_NBITS'(pop);
      pend_q  <= pend_d;
      wr_q    <= wr_d;
      waddr_q <= waddr_d;
      din_q   <= din_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      qa_mem[wp_q] <= ld_rsp_waddr;
      qd_mem[wp_q] <= ld_rsp_data;
    end
  end

`ifdef PU_RF_WB_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] sc_q, sc_d;
  logic          stall_d;

  // Counts ALU wins over a waiting queue; at the limit it forces
  // exactly one pop on the following cycle.
  always_comb begin
    sc_d    = sc_q;
    stall_d = 1'b0;
    if (pop | !avail)
      sc_d = '0;
    else if (alu_win)
      sc_d = sc_q + SW'(1);
    if (sc_d == SW'(STARVE_LIMIT)) begin
      stall_d = 1'b1;
      sc_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_q    <= '0;
      stall_q <= 1'b0;
    end else begin
      sc_q    <= sc_d;
      stall_q <= stall_d;
    end
  end
`else
  assign stall_q = 1'b0;
`endif

  assign alu_stall = stall_q;
  assign wr        = wr_q;
  assign waddr     = waddr_q;
  assign din       = din_q;
  assign proto_err = err_q;
  assign hazard    = pend_q[rd_addr0] | pend_q[rd_addr1]
                   | (wr_q & ((waddr_q == rd_addr0)
                            | (waddr_q == rd_addr1)));

endmodule
